// File: rtl/vx_barrier_ctrl_if.sv
// Barrier controller bus: arrival requests from warp control, releases to the scheduler,
// plus status vectors. master = request/scheduler side, slave = barrier controller.
interface vx_barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
);
  logic                    req_valid;
  logic                    req_ready;
  logic [NW_BITS-1:0]      req_wid;
  logic [NB_BITS-1:0]      req_id;
  logic [NW_BITS-1:0]      req_size_m1;
  logic                    rel_valid;
  logic                    rel_ready;
  logic [NUM_WARPS-1:0]    rel_wmask;
  logic [NUM_WARPS-1:0]    stalled_wmask;
  logic [NUM_BARRIERS-1:0] active_bmask;
  logic                    err_dup;

  modport master (
    output req_valid, req_wid, req_id, req_size_m1, rel_ready,
    input  req_ready, rel_valid, rel_wmask, stalled_wmask, active_bmask, err_dup
  );

  modport slave (
    input  req_valid, req_wid, req_id, req_size_m1, rel_ready,
    output req_ready, rel_valid, rel_wmask, stalled_wmask, active_bmask, err_dup
  );
endinterface

// File: rtl/vx_barrier_ctrl.sv
// Per-core warp barrier controller: counts arrivals per barrier id, holds waiting warps
// stalled and hands a single resume mask to the warp scheduler when a barrier fills.
module vx_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input logic              clk,
  input logic              reset,
  vx_barrier_ctrl_if.slave bus_if
);

  // Table is sized to the full id range so any req_id indexes a real entry.
  localparam int TBL_DEPTH = 1 << NB_BITS;

  logic [NW_BITS-1:0]   cnt_q   [TBL_DEPTH];
  logic [NW_BITS-1:0]   cnt_d   [TBL_DEPTH];
  logic [NUM_WARPS-1:0] wmask_q [TBL_DEPTH];
  logic [NUM_WARPS-1:0] wmask_d [TBL_DEPTH];
  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_wmask_q, rel_wmask_d;
  logic                 err_dup_q, err_dup_d;

  logic                 accept;
  logic [NUM_WARPS-1:0] warp_bit;
  logic [NUM_WARPS-1:0] stalled;
  logic [NB_BITS-1:0]   id;

  assign bus_if.req_ready = !rel_valid_q || bus_if.rel_ready;
  assign accept           = bus_if.req_valid && bus_if.req_ready;
  assign id               = bus_if.req_id;
  assign warp_bit         = {{(NUM_WARPS-1){1'b0}}, 1'b1} << bus_if.req_wid;

  always_comb begin
    stalled = '0;
    for (int b = 0; b < TBL_DEPTH; b++) begin
      stalled = stalled | wmask_q[b];
    end
  end

  always_comb begin
    bus_if.active_bmask = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      bus_if.active_bmask[b] = |wmask_q[b];
    end
  end

  assign bus_if.stalled_wmask = stalled;
  assign bus_if.rel_valid     = rel_valid_q;
  assign bus_if.rel_wmask     = rel_wmask_q;
  assign bus_if.err_dup       = err_dup_q;

  // A release accepted on the handshake edge overrides the clear, keeping rel_valid high.
  always_comb begin
    cnt_d       = cnt_q;
    wmask_d     = wmask_q;
    rel_valid_d = rel_valid_q;
    rel_wmask_d = rel_wmask_q;
    err_dup_d   = err_dup_q;
    if (rel_valid_q && bus_if.rel_ready) begin
      rel_valid_d = 1'b0;
    end
    if (accept) begin
      if (|(stalled & warp_bit)) begin
        err_dup_d = 1'b1;
      end else if (cnt_q[id] >= bus_if.req_size_m1) begin
        rel_valid_d = 1'b1;
        rel_wmask_d = wmask_q[id] | warp_bit;
        cnt_d[id]   = '0;
        wmask_d[id] = '0;
      end else begin
        cnt_d[id]   = cnt_q[id] + {{(NW_BITS-1){1'b0}}, 1'b1};
        wmask_d[id] = wmask_q[id] | warp_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < TBL_DEPTH; b++) begin
        cnt_q[b]   <= '0;
        wmask_q[b] <= '0;
      end
      rel_valid_q <= 1'b0;
      rel_wmask_q <= '0;
      err_dup_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wmask_q     <= wmask_d;
      rel_valid_q <= rel_valid_d;
      rel_wmask_q <= rel_wmask_d;
      err_dup_q   <= err_dup_d;
    end
  end

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Directed bench for vx_barrier_ctrl: expected release masks go to a scoreboard queue that
// a negedge monitor drains on every release handshake; status vectors are checked inline.
module tb_vx_barrier_ctrl;
  localparam int NW = 4;
  localparam int NB = 4;
  localparam int NWB = 2;
  localparam int NBB = 2;

  logic clk;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  logic [NW-1:0] expQ[$];

  vx_barrier_ctrl_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) bus ();

  vx_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every release handshake must match the oldest expected mask.
  always @(negedge clk) begin
    if (bus.rel_valid === 1'b1 && bus.rel_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL relUnexpected: got %0h expected none at %0t", bus.rel_wmask, $time);
      end else begin
        cmp("relWmask", 32'(bus.rel_wmask), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input int wid, input int id, input int sz);
    bus.req_valid   = 1'b1;
    bus.req_wid     = NWB'(wid);
    bus.req_id      = NBB'(id);
    bus.req_size_m1 = NWB'(sz);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [NW-1:0] stalled,
                             input logic [NB-1:0] active, input logic relValid,
                             input logic reqReady, input logic err);
    cmp({name, ".stalled"},  32'(bus.stalled_wmask), 32'(stalled));
    cmp({name, ".active"},   32'(bus.active_bmask),  32'(active));
    cmp({name, ".relValid"}, 32'(bus.rel_valid),     32'(relValid));
    cmp({name, ".reqReady"}, 32'(bus.req_ready),     32'(reqReady));
    cmp({name, ".errDup"},   32'(bus.err_dup),       32'(err));
  endtask

  initial begin
    reset           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_wid     = '0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    bus.rel_ready   = 1'b1;
    #3;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("reset.relWmask", 32'(bus.rel_wmask), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic barrier on id 1, three participants
    applyStimulus(0, 1, 2);
    applyStimulus(2, 1, 2);
    @(negedge clk);
    checkOutput("basicWait", 4'b0101, 4'b0010, 1'b0, 1'b1, 1'b0);
    expQ.push_back(4'b1101);
    applyStimulus(3, 1, 2);
    @(negedge clk);
    checkOutput("basicRel", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);

    // Self-release with size_m1 = 0
    expQ.push_back(4'b0010);
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("selfRel", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Backpressure: release held while rel_ready is low
    bus.rel_ready = 1'b0;
    applyStimulus(0, 2, 1);
    @(negedge clk);
    checkOutput("bpWait", 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0);
    expQ.push_back(4'b0101);
    applyStimulus(2, 2, 1);
    bus.req_valid   = 1'b1;
    bus.req_wid     = 2'd1;
    bus.req_id      = 2'd3;
    bus.req_size_m1 = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bpHold%0d", i), 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      cmp($sformatf("bpHold%0d.relWmask", i), 32'(bus.rel_wmask), 32'h5);
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.rel_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpResume", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bpDone", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back releases with rel_ready held high
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0010);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    @(negedge clk);
    checkOutput("b2b", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Duplicate arrival is dropped and sets the sticky error
    applyStimulus(2, 3, 3);
    @(negedge clk);
    checkOutput("dupFirst", 4'b0100, 4'b1000, 1'b0, 1'b1, 1'b0);
    applyStimulus(2, 3, 3);
    @(negedge clk);
    checkOutput("dupAgain", 4'b0100, 4'b1000, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 3, 3);
    applyStimulus(1, 3, 3);
    @(negedge clk);
    checkOutput("dupCnt", 4'b0111, 4'b1000, 1'b0, 1'b1, 1'b1);
    expQ.push_back(4'b1111);
    applyStimulus(3, 3, 3);
    @(negedge clk);
    checkOutput("dupRel", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Async reset with waiters and a pending (never taken) release
    applyStimulus(0, 2, 3);
    applyStimulus(1, 2, 3);
    bus.rel_ready = 1'b0;
    applyStimulus(2, 0, 0);
    @(negedge clk);
    checkOutput("preReset", 4'b0011, 4'b0100, 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncReset", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("asyncReset.relWmask", 32'(bus.rel_wmask), 32'h0);
    @(negedge clk);
    reset         = 1'b1;
    bus.rel_ready = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back(4'b1000);
    applyStimulus(3, 1, 0);
    @(negedge clk);
    checkOutput("postReset", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    cmp("sbEmpty", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
